uart_boot_loader: RTL

Framed bootloader receiver between the UART receiver and the core's instruction-memory write port. Consumes a byte stream (`rx_data`/`rx_dv`) while the top-level load mode is active. It validates a header, length and checksum, and assembles little-endian 32-bit words. Each completed word is issued as a single-cycle IMEM write with an auto-incrementing address, and the result is reported as done or error with a code.

---
 rtl/uart_boot_loader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: framed UART byte stream -> IMEM word writes.
// Frame: SYNC_BYTE, N (words), 4*N data bytes (LSB first), CSUM.
// CSUM = (N + sum of data bytes) mod 256. Words are written as they land;
// the core must be held until o_done.
module uart_boot_loader #(
  parameter int         ADDR_W       = 6,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_enable,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_dv,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_err,
  output logic [ADDR_W:0]   o_word_count
);
  localparam int CNT_W = ADDR_W + 1;
  localparam int MAX_N = 1 << ADDR_W;
  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SYNC = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  localparam logic [1:0] E_LEN  = 2'b01;
  localparam logic [1:0] E_CSUM = 2'b10;
  localparam logic [1:0] E_TMO  = 2'b11;

  logic [2:0]       state;
  logic [1:0]       lane;
  logic [23:0]      word_lo;   // lanes 0..2; lane 3 comes straight from the bus
  logic [7:0]       acc;
  logic [CNT_W-1:0] n_words;
  logic [TMO_W-1:0] tmo_cnt;
  logic             in_frame;
  logic             len_bad;
  logic             tmo_hit;

  assign in_frame = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign o_busy   = in_frame;
  assign len_bad  = (i_rx_data == 8'd0) || (int'(i_rx_data) > MAX_N);
  assign tmo_hit  = in_frame && !i_rx_dv && (tmo_cnt == TMO_LAST);

  // Idle-clock counter; only runs inside a frame, restarts on every byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            tmo_cnt <= '0;
    else if (!i_enable || !in_frame || i_rx_dv) tmo_cnt <= '0;
    else                                   tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  // Frame FSM, word assembly, checksum and IMEM write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      lane         <= '0;
      word_lo      <= '0;
      acc          <= '0;
      n_words      <= '0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_data  <= '0;
      o_done       <= 1'b0;
      o_err        <= '0;
      o_word_count <= '0;
    end else begin
      o_imem_we <= 1'b0;
      if (!i_enable) begin
        // Abort drops any partially assembled word without writing it.
        state        <= S_IDLE;
        lane         <= '0;
        acc          <= '0;
        o_done       <= 1'b0;
        o_err        <= '0;
        o_word_count <= '0;
      end else if (tmo_hit) begin
        state <= S_ERR;
        o_err <= E_TMO;
      end else begin
        case (state)
          S_IDLE: state <= S_SYNC;
          S_SYNC: if (i_rx_dv && i_rx_data == SYNC_BYTE) state <= S_LEN;
          S_LEN: if (i_rx_dv) begin
            if (len_bad) begin
              state <= S_ERR;
              o_err <= E_LEN;
            end else begin
              n_words      <= CNT_W'(i_rx_data);
              acc          <= i_rx_data;
              lane         <= '0;
              o_word_count <= '0;
              state        <= S_DATA;
            end
          end
          S_DATA: if (i_rx_dv) begin
            acc  <= acc + i_rx_data;
            lane <= lane + 2'd1;
            case (lane)
              2'd0: word_lo[7:0]   <= i_rx_data;
              2'd1: word_lo[15:8]  <= i_rx_data;
              2'd2: word_lo[23:16] <= i_rx_data;
              default: begin
                o_imem_we    <= 1'b1;
                o_imem_data  <= {i_rx_data, word_lo};
                o_imem_addr  <= o_word_count[ADDR_W-1:0];
                o_word_count <= o_word_count + CNT_W'(1);
                if (o_word_count + CNT_W'(1) == n_words) state <= S_CSUM;
              end
            endcase
          end
          S_CSUM: if (i_rx_dv) begin
            if (i_rx_data == acc) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end else begin
              state <= S_ERR;
              o_err <= E_CSUM;
            end
          end
          S_DONE, S_ERR: ;  // held until load mode drops
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
